// File: rtl/lpc_uart_tx.sv
// 8N1 UART transmitter for the LPC UART bridge: a small byte FIFO feeding an
// LSB-first serialiser, with bit timing counted in lpc_clk cycles.
module lpc_uart_tx #(
  parameter int CLKS_PER_BIT = 286,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               lpc_clk,
  input  logic                               lpc_rst,
  input  logic                               wr_en,
  input  logic [7:0]                         wr_data,
  output logic                               fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow,
  output logic                               busy,
  output logic                               uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ovf;

  logic w_full, w_push, w_pop, w_bit_end;

  assign w_full    = (r_count == FULL_CNT);
  assign w_push    = wr_en && !w_full;
  assign w_bit_end = (r_baud == '0);
  // The head leaves the FIFO either from IDLE or on the last STOP cycle, which
  // is what makes back-to-back frames seamless.
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  always_ff @(posedge lpc_clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= wr_en && w_full;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_baud  <= BAUD_TOP;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= BAUD_TOP;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_TOP;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // tx is registered, so drive the next bit as the shift happens
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_baud  <= BAUD_TOP;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign uart_tx    = r_tx;

endmodule

// File: tb/tb_lpc_uart_tx.sv
// Bench for lpc_uart_tx: two instances (286 and 2 clocks per bit) checked
// against a frame-schedule model of the serial line and FIFO occupancy.
module tb_lpc_uart_tx;
  localparam int DEPTH = 4;
  localparam int NF    = 256;

  int cpb [2] = '{286, 2};

  logic       clk = 1'b0;
  logic [1:0] rst_n, wr_en, tx, busy, full, ovf;
  logic [7:0] wd  [2];
  logic [2:0] cnt [2];

  always #5 clk = ~clk;

  lpc_uart_tx #(.CLKS_PER_BIT(286), .FIFO_DEPTH(DEPTH)) u_d0 (
    .lpc_clk(clk), .lpc_rst(rst_n[0]), .wr_en(wr_en[0]), .wr_data(wd[0]),
    .fifo_full(full[0]), .fifo_count(cnt[0]), .overflow(ovf[0]),
    .busy(busy[0]), .uart_tx(tx[0]));

  lpc_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) u_d1 (
    .lpc_clk(clk), .lpc_rst(rst_n[1]), .wr_en(wr_en[1]), .wr_data(wd[1]),
    .fifo_full(full[1]), .fifo_count(cnt[1]), .overflow(ovf[1]),
    .busy(busy[1]), .uart_tx(tx[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted byte has an accept edge, a start edge and a value.
  int         fa [2][NF];
  int         fs [2][NF];
  logic [7:0] fb [2][NF];
  int         drops [2][NF];
  int         nf [2] = '{0, 0};
  int         nd [2] = '{0, 0};
  int         lf [2] = '{0, 0};
  int         merr [2] = '{0, 0};
  int         mfirst [2] = '{0, 0};
  int         checks = 0;
  int         failures = 0;
  logic [7:0] bs [6];

  function automatic int m_cnt(int d, int k);
    int n = 0;
    for (int i = 0; i < nf[d]; i++) if (fa[d][i] <= k && k < fs[d][i]) n++;
    return n;
  endfunction

  function automatic logic m_active(int d, int k);
    for (int i = 0; i < nf[d]; i++)
      if (k >= fs[d][i] && k < fs[d][i] + 10*cpb[d]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_tx(int d, int k);
    int idx;
    for (int i = 0; i < nf[d]; i++)
      if (k >= fs[d][i] && k < fs[d][i] + 10*cpb[d]) begin
        idx = (k - fs[d][i]) / cpb[d];
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return fb[d][i][idx-1];
      end
    return 1'b1;
  endfunction

  function automatic logic m_ovf(int d, int k);
    for (int i = 0; i < nd[d]; i++) if (drops[d][i] == k) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] === 1'b1) begin
        if ((tx[d] !== m_tx(d, cyc)) ||
            (busy[d] !== ((m_cnt(d, cyc) != 0) || m_active(d, cyc))) ||
            (cnt[d] !== 3'(m_cnt(d, cyc))) ||
            (full[d] !== (m_cnt(d, cyc) == DEPTH)) ||
            (ovf[d] !== m_ovf(d, cyc))) begin
          if (merr[d] == 0) mfirst[d] <= cyc;
          merr[d] <= merr[d] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_edge(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int d);
    nf[d] = 0; nd[d] = 0; lf[d] = 0;
  endtask

  // Drive one write for the next edge and record its fate in the model.
  task automatic wr(input int d, input logic [7:0] b, output int s);
    int e, n;
    e = cyc + 1;
    n = 0;
    for (int i = 0; i < nf[d]; i++) if (fs[d][i] >= e) n++;
    wr_en[d] = 1'b1;
    wd[d] = b;
    if (n == DEPTH) begin
      drops[d][nd[d]] = e; nd[d]++; s = -1;
    end else begin
      s = (lf[d] > e + 1) ? lf[d] : e + 1;
      fa[d][nf[d]] = e; fs[d][nf[d]] = s; fb[d][nf[d]] = b; nf[d]++;
      lf[d] = s + 10*cpb[d];
    end
    @(posedge clk); #1;
    wr_en[d] = 1'b0;
  endtask

  task automatic decode(input int d, input int s, output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      at_edge(s + cpb[d]*(i+1) + cpb[d]/2);
      b[i] = tx[d];
    end
  endtask

  initial begin
    int e, s, s0, sx;
    logic [7:0] b;
    rst_n = 2'b00; wr_en = 2'b00; wd[0] = 8'h00; wd[1] = 8'h00;
    idle(3);
    chk("rst_tx", tx, 2'b11);
    chk("rst_busy", busy, 2'b00);
    chk("rst_cnt", cnt[0], 0);
    chk("rst_full_ovf", {full, ovf}, 4'b0000);
    rst_n = 2'b11;
    idle(10);
    chk("idle_tx", tx, 2'b11);
    chk("idle_busy", busy, 2'b00);
    chk("idle_cnt", cnt[0], 0);

    // Reset in the middle of a frame with a byte still queued
    wr(0, 8'h3C, s);
    wr(0, 8'h55, s0);
    at_edge(s + 500);
    chk("prerst_tx", tx[0], 0);
    chk("prerst_cnt", cnt[0], 1);
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_tx", tx[0], 1);
    chk("midrst_cnt", cnt[0], 0);
    chk("midrst_busy", busy[0], 0);
    model_reset(0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    idle(5);

    // Single byte 0x0F
    e = cyc + 1;
    wr(0, 8'h0F, s);
    at_edge(e + 1);    chk("t2_start_first", tx[0], 0);
    at_edge(e + 286);  chk("t2_start_last", tx[0], 0);
    at_edge(e + 287);  chk("t2_bit0", tx[0], 1);
    decode(0, e + 1, b);
    chk("t2_byte", b, 8'h0F);
    at_edge(e + 1 + 9*286); chk("t2_stop", tx[0], 1);
    at_edge(e + 2860); chk("t2_busy_hi", busy[0], 1);
    at_edge(e + 2861); chk("t2_busy_lo", busy[0], 0);

    // Two bytes on consecutive cycles
    e = cyc + 1;
    wr(0, 8'hA5, s);
    wr(0, 8'hF0, s);
    at_edge(e + 1); chk("t3_cnt", cnt[0], 1);
    decode(0, e + 1, b); chk("t3_byte0", b, 8'hA5);
    at_edge(e + 2860); chk("t3_stop_end", tx[0], 1);
    at_edge(e + 2861); chk("t3_start2", tx[0], 0);
    decode(0, e + 2861, b); chk("t3_byte1", b, 8'hF0);
    at_edge(e + 5722); chk("t3_done", busy[0], 0);

    // Six writes into a four-deep FIFO
    e = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      bs[i] = 8'($urandom);
      wr(0, bs[i], s);
      chk($sformatf("t4_cnt%0d", i), cnt[0], (i == 0) ? 1 : (i >= 4 ? 4 : i));
      chk($sformatf("t4_full%0d", i), full[0], (i >= 4) ? 1 : 0);
      chk($sformatf("t4_ovf%0d", i), ovf[0], (i == 5) ? 1 : 0);
    end
    at_edge(e + 6); chk("t4_ovf_pulse_end", ovf[0], 0);
    for (int j = 0; j < 5; j++) begin
      decode(0, e + 1 + 2860*j, b);
      chk($sformatf("t4_byte%0d", j), b, bs[j]);
    end
    at_edge(e + 1 + 5*2860 + 10);
    chk("t4_done_busy", busy[0], 0);
    chk("t4_done_tx", tx[0], 1);

    // Push coinciding with the end-of-STOP pop
    e = cyc + 1;
    sx = e + 1;
    wr(0, 8'h81, s);
    idle(100);
    wr(0, 8'h3E, s);
    decode(0, sx, b); chk("t5_byte0", b, 8'h81);
    at_edge(sx + 2859);
    wr(0, 8'hC7, s);
    chk("t5_cnt", cnt[0], 1);
    chk("t5_start1", tx[0], 0);
    decode(0, sx + 2860, b); chk("t5_byte1", b, 8'h3E);
    decode(0, sx + 5720, b); chk("t5_byte2", b, 8'hC7);
    at_edge(sx + 8582); chk("t5_done", busy[0], 0);

    // Two clocks per bit, back-to-back 0x00 then 0xFF
    e = cyc + 1;
    s0 = e + 1;
    wr(1, 8'h00, s);
    wr(1, 8'hFF, s);
    decode(1, s0, b); chk("t6_byte0", b, 8'h00);
    at_edge(s0 + 19); chk("t6_stop0", tx[1], 1);
    at_edge(s0 + 20); chk("t6_start1", tx[1], 0);
    decode(1, s0 + 20, b); chk("t6_byte1", b, 8'hFF);
    at_edge(s0 + 39); chk("t6_stop1", tx[1], 1);
    at_edge(s0 + 40); chk("t6_done", busy[1], 0);

    // Randomized traffic on both instances
    repeat (300) begin
      if ($urandom_range(0, 2) == 0) wr(1, 8'($urandom), s);
      else idle(1);
    end
    repeat (6) begin
      idle($urandom_range(1, 600));
      wr(0, 8'($urandom), s);
    end
    at_edge(((lf[0] > lf[1]) ? lf[0] : lf[1]) + 3);
    chk("rand_busy", busy, 2'b00);
    chk("model_d0", merr[0], 0);
    chk("model_d1", merr[1], 0);
    if (merr[0] != 0 || merr[1] != 0)
      $display("first model divergence cycles d0=%0d d1=%0d", mfirst[0], mfirst[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lpc_uart_tx.md
Name: lpc_uart_tx

Overview:
- 8N1 UART transmitter for the LPC UART bridge; the transmit counterpart to the existing receive path.
- Accepts bytes from the LPC register side through a small FIFO and serialises them onto uart_tx, LSB first.
- Runs entirely in the lpc_clk domain. Bit timing is derived by counting lpc_clk cycles: 286 cycles per bit, which is 33 MHz / 115200.

Parameters:
- CLKS_PER_BIT, 286, lpc_clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2, minimum 2.

Ports:
- lpc_clk  input  1  LPC clock; all logic is on the rising edge.
- lpc_rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  push wr_data into the FIFO on this edge.
- wr_data  input  8  byte to transmit.
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes waiting in the FIFO; excludes the byte currently being shifted.
- overflow  output  1  one-cycle pulse when a write is dropped.
- busy  output  1  high when the serialiser is not IDLE or the FIFO is non-empty.
- uart_tx  output  1  serial line; idle high; registered output.

Behaviour:
- Reset (lpc_rst low, asynchronous):
  - uart_tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - State=IDLE; FIFO pointers, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately: uart_tx returns high on assertion and FIFO contents are discarded.
- FIFO:
  - A write is accepted when wr_en=1 and fifo_full=0, sampled before the edge.
  - Write with fifo_full=1: data dropped; overflow=1 for exactly the next cycle. This holds even if a pop occurs on the same edge.
  - Pop happens only in IDLE, or at the end of STOP, when fifo_count>0 before the edge.
  - Push and pop on the same edge leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: uart_tx=1. If fifo_count>0, pop the head into the shift register, load the baud counter, and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if fifo_count>0, pop and go straight to START (back-to-back, no extra idle cycle); otherwise go to IDLE.
- Latency:
  - If wr_en is accepted at edge E with the FIFO empty and state IDLE, the byte becomes visible at E.
  - The pop happens at E+1, and uart_tx falls at E+1 (registered together with the state change).
- Frame length:
  - Exactly 10*CLKS_PER_BIT cycles per frame.
  - No cycle is gained or lost between consecutive back-to-back frames.
- Baud counter:
  - Counts down from CLKS_PER_BIT-1 to 0; the state/bit advances on the 0 cycle.
  - Width $clog2(CLKS_PER_BIT).
- busy=0 only when state=IDLE and fifo_count=0. It deasserts on the edge the last stop bit completes.
- wr_data is sampled only on accepted writes and is don't-care otherwise.

Test Plan:
1. Reset, then hold 10 cycles → uart_tx=1, busy=0, fifo_count=0. Assert lpc_rst low mid-frame → uart_tx=1 within the same cycle and fifo_count=0.
2. Write 0x0F at edge E → uart_tx=0 from E+1 for 286 cycles. Then the bit sequence is 1,1,1,1,0,0,0,0, each 286 cycles, followed by stop=1 for 286 cycles. busy falls at E+1+2860.
3. Write 0xA5 then 0xF0 on consecutive cycles:
   - fifo_count reads 1 (the 0xA5 pop and the 0xF0 push coincide).
   - 0xF0's start bit begins exactly 2860 cycles after 0xA5's start bit.
   - Decoded bytes are 0xA5, 0xF0.
4. With CLKS_PER_BIT=286 and FIFO_DEPTH=4, write 6 bytes on consecutive cycles:
   - The first pops immediately; fifo_full asserts after the 5th write.
   - The 6th write produces a single overflow pulse.
   - Exactly 5 frames are transmitted, in order.
5. Write when the FIFO has 1 entry while in STOP, pushing on the same edge as the end-of-STOP pop → fifo_count stays 1 and no frame is lost or duplicated.
6. Set CLKS_PER_BIT=2 and stream 0x00, 0xFF → each frame is 20 cycles, with correct start/stop levels and no glitch on uart_tx between frames.
